// File: rtl/divider_signed_seq_param.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per clock,
// with sign fix-up and saturation registered as the result enters DONE.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | restoring steps; a zero divisor passes through for a single edge
// DONE  | result held with out_valid=1 until out_ready
module divider_signed_seq_param #(
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  dividend,
  input  logic [DATA_IN_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] quotient,
  output logic [DATA_IN_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int W  = DATA_IN_WIDTH;
  localparam int O  = DATA_OUT_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [O-1:0] MAXQ     = {1'b0, {(O-1){1'b1}}};
  localparam logic [O-1:0] MINQ     = {1'b1, {(O-1){1'b0}}};
  localparam logic [W-1:0] MAXQ_MAG = W'((64'd1 << (O - 1)) - 64'd1);
  localparam logic [W-1:0] MINQ_MAG = W'(64'd1 << (O - 1));

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W:0]    rem_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dsr_q;
  logic          sd_q;
  logic          sv_q;
  logic          dz_q;

  logic [W+1:0]  rem_sh;
  logic [W+1:0]  dsr_ext;
  logic          take;
  logic [W:0]    rem_nx;
  logic [W-1:0]  dvd_nx;
  logic [W-1:0]  r_src;
  logic [W-1:0]  r_fix;
  logic [O-1:0]  q_fix;
  logic          ovf_fix;
  logic          qneg;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Dividend magnitude doubles as the quotient shift register: bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[W-1]};
    dsr_ext = {2'b00, dsr_q};
    take    = (rem_sh >= dsr_ext);
    rem_nx  = take ? (W+1)'(rem_sh - dsr_ext) : (W+1)'(rem_sh);
    dvd_nx  = {dvd_q[W-2:0], take};
  end

  always_comb begin
    qneg    = sd_q ^ sv_q;
    q_fix   = '0;
    ovf_fix = 1'b0;
    if (dz_q) begin
      q_fix = sd_q ? MINQ : MAXQ;
    end else if (!qneg) begin
      if (dvd_nx > MAXQ_MAG) begin
        q_fix   = MAXQ;
        ovf_fix = 1'b1;
      end else begin
        q_fix = O'(dvd_nx);
      end
    end else begin
      if (dvd_nx > MINQ_MAG) begin
        q_fix   = MINQ;
        ovf_fix = 1'b1;
      end else begin
        q_fix = O'(-dvd_nx);
      end
    end
    // On a zero divisor the untouched dividend magnitude is returned as the remainder.
    r_src = dz_q ? dvd_q : rem_nx[W-1:0];
    r_fix = sd_q ? -r_src : r_src;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      sd_q        <= 1'b0;
      sv_q        <= 1'b0;
      dz_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend[W-1] ? -dividend : dividend;
            dsr_q <= divisor[W-1] ? -divisor : divisor;
            sd_q  <= dividend[W-1];
            sv_q  <= divisor[W-1];
            rem_q <= '0;
            dz_q  <= (divisor == '0);
            cnt   <= (divisor == '0) ? CW'(1) : CW'(W);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= dz_q;
            overflow    <= ovf_fix;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_signed_seq_param.sv
// Bench for divider_signed_seq_param: directed corner cases plus randomized operands on
// three width configurations, checked against plain integer division with saturation.
module tb_divider_signed_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  irdy;
  logic [2:0]  ov;
  logic [2:0]  dz;
  logic [2:0]  ovf;
  logic [7:0]  dd8, ds8;
  logic [11:0] dd12, ds12;
  logic [7:0]  q8;
  logic [3:0]  q4;
  logic [5:0]  q12;
  logic [7:0]  r8, r4;
  logic [11:0] r12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider_signed_seq_param #(.DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .dividend(dd8), .divisor(ds8), .out_valid(ov[0]), .out_ready(ordy[0]),
    .quotient(q8), .remainder(r8), .div_by_zero(dz[0]), .overflow(ovf[0]));

  divider_signed_seq_param #(.DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(4)) u_div4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .dividend(dd8), .divisor(ds8), .out_valid(ov[1]), .out_ready(ordy[1]),
    .quotient(q4), .remainder(r4), .div_by_zero(dz[1]), .overflow(ovf[1]));

  divider_signed_seq_param #(.DATA_IN_WIDTH(12), .DATA_OUT_WIDTH(6)) u_div12 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .dividend(dd12), .divisor(ds12), .out_valid(ov[2]), .out_ready(ordy[2]),
    .quotient(q12), .remainder(r12), .div_by_zero(dz[2]), .overflow(ovf[2]));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int get_q(input int s);
    case (s)
      0:       get_q = int'($signed(q8));
      1:       get_q = int'($signed(q4));
      default: get_q = int'($signed(q12));
    endcase
  endfunction

  function automatic int get_r(input int s);
    case (s)
      0:       get_r = int'($signed(r8));
      1:       get_r = int'($signed(r4));
      default: get_r = int'($signed(r12));
    endcase
  endfunction

  function automatic int in_w(input int s);
    in_w = (s == 2) ? 12 : 8;
  endfunction

  function automatic int out_w(input int s);
    out_w = (s == 0) ? 8 : ((s == 1) ? 4 : 6);
  endfunction

  // Reference: truncating integer division, remainder signed like the dividend, saturated quotient.
  task automatic ref_div(input int a, input int b, input int o,
                         output int q, output int r, output int edz, output int eovf);
    int maxq, minq, qt;
    maxq = (1 << (o - 1)) - 1;
    minq = -(1 << (o - 1));
    edz  = (b == 0) ? 1 : 0;
    eovf = 0;
    if (b == 0) begin
      q = (a >= 0) ? maxq : minq;
      r = a;
    end else begin
      qt = a / b;
      r  = a % b;
      if (qt > maxq) begin
        q = maxq; eovf = 1;
      end else if (qt < minq) begin
        q = minq; eovf = 1;
      end else begin
        q = qt;
      end
    end
  endtask

  task automatic set_ops(input int s, input int a, input int b);
    if (s == 2) begin
      dd12 = a[11:0];
      ds12 = b[11:0];
    end else begin
      dd8 = a[7:0];
      ds8 = b[7:0];
    end
  endtask

  function automatic int rnd_val(input int w);
    int lo, hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    case ($urandom_range(0, 11))
      0:       rnd_val = 0;
      1:       rnd_val = -1;
      2:       rnd_val = 1;
      3:       rnd_val = lo;
      4:       rnd_val = hi;
      default: rnd_val = int'($urandom_range(0, (1 << w) - 1)) + lo;
    endcase
  endfunction

  task automatic check_result(input int s, input int eq, input int er, input int edz, input int eovf);
    check_val("quotient", get_q(s), eq);
    check_val("remainder", get_r(s), er);
    check_val("div_by_zero", int'(dz[s]), edz);
    check_val("overflow", int'(ovf[s]), eovf);
  endtask

  // One full transaction: accept, count latency (optionally poking in_valid while busy), hold, drain.
  task automatic do_op(input int s, input int a, input int b, input int hold, input bit poke);
    int eq, er, edz, eovf, lat;
    ref_div(a, b, out_w(s), eq, er, edz, eovf);
    @(negedge clk);
    check_val("in_ready_idle", int'(irdy[s]), 1);
    set_ops(s, a, b);
    iv[s] = 1'b1;
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    lat = 0;
    while (!ov[s] && lat < 40) begin
      check_val("in_ready_busy", int'(irdy[s]), 0);
      if (poke) begin
        iv[s] = 1'($urandom_range(0, 1));
        set_ops(s, int'($urandom), int'($urandom));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    iv[s] = 1'b0;
    check_val("latency", lat, (edz != 0) ? 1 : in_w(s));
    check_result(s, eq, er, edz, eovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val("hold_out_valid", int'(ov[s]), 1);
      check_val("hold_in_ready", int'(irdy[s]), 0);
      check_result(s, eq, er, edz, eovf);
    end
    @(negedge clk);
    ordy[s] = 1'b1;
    @(posedge clk);
    #1;
    ordy[s] = 1'b0;
    check_val("drain_out_valid", int'(ov[s]), 0);
    check_val("drain_in_ready", int'(irdy[s]), 1);
    check_val("drain_dz_clear", int'(dz[s]), 0);
    check_val("drain_ovf_clear", int'(ovf[s]), 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    dd8  = '0;
    ds8  = '0;
    dd12 = '0;
    ds12 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_val("reset_in_ready", int'(irdy[s]), 1);
      check_val("reset_out_valid", int'(ov[s]), 0);
      check_result(s, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    do_op(0, 100, 7, 0, 0);
    do_op(0, -100, 7, 0, 0);
    do_op(0, 100, -7, 0, 0);
    do_op(0, -100, -7, 0, 0);
    do_op(0, -128, -1, 0, 0);
    do_op(0, -128, 1, 0, 0);
    do_op(1, 100, 7, 0, 0);
    do_op(0, 5, 0, 0, 0);
    do_op(0, -5, 0, 0, 0);
    do_op(0, 50, 3, 5, 1);
    do_op(2, -2048, -1, 2, 1);

    // Abort an operation mid-flight with reset.
    @(negedge clk);
    set_ops(0, 77, 5);
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", int'(ov[0]), 0);
    check_val("abort_in_ready", int'(irdy[0]), 1);
    check_result(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 9, 3, 0, 0);

    for (int i = 0; i < 1500; i++)
      do_op(0, rnd_val(8), rnd_val(8), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++)
      do_op(1, rnd_val(8), rnd_val(8), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1500; i++)
      do_op(2, rnd_val(12), rnd_val(12), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
